// File: rtl/trade_counter_mc.sv
// Multi-channel trade counter with per-window rate limit and total-trade halt; counts update 1 cycle after match.
// No backpressure: rejected matches are lost and flagged on dropped the following cycle.
module trade_counter_mc #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 8,
  parameter int MAX_TRADES = 100,
  parameter int WINDOW     = 16,
  parameter int WIN_MAX    = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable_count,
  input  logic [NUM_CH-1:0]       match_signal,
  input  logic                    resume,
  output logic [NUM_CH*CNT_W-1:0] ch_count,
  output logic [CNT_W-1:0]        trade_count,
  output logic                    throttle,
  output logic                    halt_signal,
  output logic                    dropped
);

  localparam int WC_W = $clog2(WINDOW);
  localparam logic [CNT_W-1:0] MAX_C    = CNT_W'(MAX_TRADES);
  localparam logic [CNT_W-1:0] WIN_C    = CNT_W'(WIN_MAX);
  localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);

  typedef enum logic [1:0] {RUN, THROTTLE, HALT} state_t;

  state_t                       state, nxt_state;
  logic [NUM_CH-1:0][CNT_W-1:0] ch_cnt;
  logic [CNT_W-1:0]             win_trades;
  logic [WC_W-1:0]              win_cyc;

  logic [NUM_CH-1:0] acc_mask;
  logic [CNT_W-1:0]  acc_n, limit, room_tot, room_win, new_tc, new_wt;
  logic              win_last;

  assign ch_count = ch_cnt;
  assign win_last = (win_cyc == WIN_LAST);
  assign room_tot = MAX_C - trade_count;
  assign room_win = WIN_C - win_trades;
  assign new_tc   = trade_count + acc_n;
  assign new_wt   = win_trades + acc_n;

  // Grant offered bits in ascending channel order until the tighter budget runs out.
  always_comb begin
    acc_mask = '0;
    acc_n    = '0;
    limit    = (room_tot < room_win) ? room_tot : room_win;
    if (state == RUN && enable_count) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (match_signal[i] && acc_n < limit) begin
          acc_mask[i] = 1'b1;
          acc_n       = acc_n + CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    nxt_state = state;
    case (state)
      RUN: begin
        if (new_tc == MAX_C)
          nxt_state = HALT;
        else if (new_wt == WIN_C && !win_last)
          nxt_state = THROTTLE;
      end
      THROTTLE: if (win_last) nxt_state = RUN;
      HALT:     if (resume) nxt_state = RUN;
      default:  nxt_state = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      ch_cnt      <= '0;
      trade_count <= '0;
      win_trades  <= '0;
      win_cyc     <= '0;
      throttle    <= 1'b0;
      halt_signal <= 1'b0;
      dropped     <= 1'b0;
    end else begin
      state       <= nxt_state;
      throttle    <= (nxt_state == THROTTLE);
      halt_signal <= (nxt_state == HALT);
      dropped     <= enable_count && |(match_signal & ~acc_mask);
      win_cyc     <= win_last ? '0 : win_cyc + WC_W'(1);
      // Trades accepted on the wrap cycle belong to the window that is ending.
      win_trades  <= win_last ? '0 : new_wt;
      trade_count <= new_tc;
      for (int i = 0; i < NUM_CH; i++) begin
        if (acc_mask[i]) ch_cnt[i] <= ch_cnt[i] + CNT_W'(1);
      end
      if (state == HALT && resume) begin
        ch_cnt      <= '0;
        trade_count <= '0;
        win_trades  <= '0;
        win_cyc     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_trade_counter_mc.sv
// Directed bench for trade_counter_mc at default parameters.
module tb_trade_counter_mc;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable_count;
  logic [3:0]  match_signal;
  logic        resume;
  logic [31:0] ch_count;
  logic [7:0]  trade_count;
  logic        throttle;
  logic        halt_signal;
  logic        dropped;

  int vectors = 0;
  int miscompares = 0;

  trade_counter_mc dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable_count(enable_count),
    .match_signal(match_signal),
    .resume      (resume),
    .ch_count    (ch_count),
    .trade_count (trade_count),
    .throttle    (throttle),
    .halt_signal (halt_signal),
    .dropped     (dropped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ch(input int i);
    return ch_count[i*8 +: 8];
  endfunction

  task automatic chk_all(input string tag, input logic [7:0] c0, input logic [7:0] c1,
                         input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] tc,
                         input logic thr, input logic hlt, input logic drp);
    chk({tag, "_ch0"}, ch(0), c0);
    chk({tag, "_ch1"}, ch(1), c1);
    chk({tag, "_ch2"}, ch(2), c2);
    chk({tag, "_ch3"}, ch(3), c3);
    chk({tag, "_tc"}, trade_count, tc);
    chk({tag, "_thr"}, throttle, thr);
    chk({tag, "_halt"}, halt_signal, hlt);
    chk({tag, "_drop"}, dropped, drp);
  endtask

  initial begin
    int budget;
    reset_n = 1'b0; enable_count = 1'b0; match_signal = 4'b0000; resume = 1'b0;
    #2;
    chk_all("reset", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Offers during reset must not be accepted.
    enable_count = 1'b1; match_signal = 4'b1111;
    tick(); tick();
    chk_all("in_reset", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Single channel held from win_cyc 0: 8 accepted, then throttled until wrap.
    reset_n = 1'b1; match_signal = 4'b0001;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("w1_ch0", ch(0), (k < 8) ? k : 8);
      chk("w1_thr", throttle, (k >= 8 && k <= 15) ? 1 : 0);
      chk("w1_drop", dropped, (k >= 9) ? 1 : 0);
    end
    chk("w1_tc", trade_count, 8);

    // Six more in the new window, then all four offered with room for two.
    for (int k = 1; k <= 6; k++) tick();
    chk_all("w2_six", 14, 0, 0, 0, 14, 1'b0, 1'b0, 1'b0);
    match_signal = 4'b1111;
    tick();
    chk_all("w2_prio", 15, 1, 0, 0, 16, 1'b1, 1'b0, 1'b1);

    // resume while throttled is ignored.
    match_signal = 4'b0000; resume = 1'b1;
    tick();
    resume = 1'b0;
    chk_all("res_thr", 15, 1, 0, 0, 16, 1'b1, 1'b0, 1'b0);

    // Disabled: offers ignored, never dropped; throttle clears at wrap.
    enable_count = 1'b0; match_signal = 4'b1111;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("dis_drop", dropped, 0);
      chk("dis_tc", trade_count, 16);
    end
    chk_all("dis_end", 15, 1, 0, 0, 16, 1'b0, 1'b0, 1'b0);

    // resume while running is ignored.
    enable_count = 1'b1; match_signal = 4'b0000; resume = 1'b1;
    tick();
    resume = 1'b0;
    chk_all("res_run", 15, 1, 0, 0, 16, 1'b0, 1'b0, 1'b0);

    // Run channel 0 up to the total limit.
    match_signal = 4'b0001;
    budget = 500;
    while (budget > 0) begin
      tick();
      budget--;
      if (trade_count == 8'd100) break;
      chk("pre_halt", halt_signal, 0);
    end
    chk("halt_edge", halt_signal, 1);
    chk_all("halted", 99, 1, 0, 0, 100, 1'b0, 1'b1, 1'b0);
    tick();
    chk_all("halt_sat", 99, 1, 0, 0, 100, 1'b0, 1'b1, 1'b1);

    // resume clears everything; the offer in that cycle is dropped.
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk_all("resume", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_all("post_res", 1, 0, 0, 0, 1, 1'b0, 1'b0, 1'b0);

    // Build to 50, then assert reset mid-cycle.
    budget = 300;
    while (budget > 0 && trade_count != 8'd50) begin
      tick();
      budget--;
    end
    chk("tc50", trade_count, 50);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    reset_n = 1'b1; match_signal = 4'b0000;
    tick();
    chk_all("after_rst", 0, 0, 0, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/trade_counter_mc.md
TRADE_COUNTER_MC -- requirements
Module: trade_counter_mc

Interface
REQ-001 Parameter NUM_CH, default 4, number of independent match channels.
REQ-002 Parameter CNT_W, default 8, width of every count output.
REQ-003 Parameter MAX_TRADES, default 100, total accepted trades before halt; SHALL satisfy 0 < MAX_TRADES < 2^CNT_W.
REQ-004 Parameter WINDOW, default 16, rate-window length in clk cycles; SHALL be >= 2.
REQ-005 Parameter WIN_MAX, default 8, maximum accepted trades per window; SHALL satisfy 1 <= WIN_MAX <= MAX_TRADES.
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 reset_n  input  1  reset; asynchronous assertion, active-low.
REQ-008 enable_count  input  1  high = match bits may be accepted.
REQ-009 match_signal  input  NUM_CH  bit i high = one trade offered on channel i this cycle.
REQ-010 resume  input  1  single-cycle request to leave HALT and restart counting.
REQ-011 ch_count  output  NUM_CH*CNT_W  per-channel accepted count; channel i at bits [i*CNT_W +: CNT_W].
REQ-012 trade_count  output  CNT_W  total accepted trades, all channels.
REQ-013 throttle  output  1  high while state is THROTTLE.
REQ-014 halt_signal  output  1  high while state is HALT.
REQ-015 dropped  output  1  registered pulse: at least one offered match rejected in the previous cycle.

Function
REQ-016 FSM states SHALL be RUN, THROTTLE and HALT; every output SHALL be a register.
REQ-017 Window timer win_cyc SHALL count 0..WINDOW-1 and wrap to 0 every cycle in every state, independent of enable_count.
REQ-018 A match bit SHALL be accepted only when state is RUN and enable_count is 1.
REQ-019 Accepted count per cycle SHALL be min(popcount(match_signal), MAX_TRADES - trade_count, WIN_MAX - win_trades).
REQ-020 When fewer bits are accepted than offered, the lowest-indexed channels SHALL win.
REQ-021 Each accepted bit SHALL increment its ch_count by 1; trade_count and internal win_trades SHALL each increase by the accepted total.
REQ-022 All count updates SHALL be visible after the same rising edge that samples match_signal (latency 1 cycle).
REQ-023 dropped SHALL be 1 in the cycle after any offered bit was rejected while enable_count = 1, else 0.
REQ-024 With enable_count = 0, match bits SHALL be ignored and dropped SHALL remain 0.
REQ-025 RUN -> HALT SHALL occur on the edge where trade_count becomes MAX_TRADES; HALT takes precedence over THROTTLE.
REQ-026 RUN -> THROTTLE SHALL occur on the edge where win_trades becomes WIN_MAX, unless win_cyc = WINDOW-1 on that edge, in which case the state SHALL stay RUN.
REQ-027 At the window wrap (win_cyc = WINDOW-1), win_trades SHALL load 0; trades accepted in that cycle count toward the ending window; THROTTLE -> RUN.
REQ-028 In HALT, a resume pulse SHALL clear all counts, win_trades and win_cyc, and enter RUN on the next edge; matches offered in that cycle are dropped.
REQ-029 resume in RUN or THROTTLE SHALL be ignored.
REQ-030 Counts SHALL never wrap; trade_count SHALL saturate at MAX_TRADES.

Reset
REQ-031 reset_n = 0 SHALL immediately set state RUN and clear all counts, win_trades, win_cyc, throttle, halt_signal and dropped to 0, regardless of clk.
REQ-032 Release of reset_n SHALL take effect at the next rising edge; no accept occurs in the cycle reset_n is low.

Verification (defaults NUM_CH=4, MAX_TRADES=100, WINDOW=16, WIN_MAX=8)
REQ-033 enable=1, match=4'b0001 held from win_cyc 0 -> ch_count[0]=8 after 8 edges; throttle=1 and dropped=1 during cycles 8-15; RUN resumes at wrap.
REQ-034 win_trades=6, match=4'b1111 for one cycle -> ch0 and ch1 +1, ch2 and ch3 unchanged, throttle=1, dropped=1.
REQ-035 Continuous match=4'b0001 until trade_count=100 -> halt_signal=1 on that edge; further matches leave count at 100 with dropped=1.
REQ-036 resume pulse in HALT -> all counts 0, halt_signal=0, next match increments to 1; resume in RUN -> no change.
REQ-037 enable_count=0 with match=4'b1111 for 20 cycles -> all counts unchanged, dropped=0.
REQ-038 reset_n pulled low mid-cycle with trade_count=50 -> all outputs 0 before the next clk edge.
